// File: rtl/display7seg_mux.sv
// Multiplexed hex 7-segment driver. A prescaler walks a digit index across
// N_DIGITS time slots; each slot opens with a short all-off blank to kill
// ghosting. New content is double-buffered and only swapped in at the frame
// boundary, so a scan never mixes old and new digits.

// Per-digit decoder: hex nibble to active-low g..a, or all-off when suppressed.
module display7seg_digit (
  input  logic [3:0] i_hex,
  input  logic       i_supp,
  output logic [6:0] o_seg
);

  // Combinational hex decode with leading-zero blanking override
  always_comb begin
    o_seg = 7'b1111111;
    if (!i_supp) begin
      case (i_hex)
        4'h0: o_seg = 7'b1000000;
        4'h1: o_seg = 7'b1111001;
        4'h2: o_seg = 7'b0100100;
        4'h3: o_seg = 7'b0110000;
        4'h4: o_seg = 7'b0011001;
        4'h5: o_seg = 7'b0010010;
        4'h6: o_seg = 7'b0000010;
        4'h7: o_seg = 7'b1111000;
        4'h8: o_seg = 7'b0000000;
        4'h9: o_seg = 7'b0010000;
        4'hA: o_seg = 7'b0001000;
        4'hB: o_seg = 7'b0000011;
        4'hC: o_seg = 7'b1000110;
        4'hD: o_seg = 7'b0100001;
        4'hE: o_seg = 7'b0000110;
        default: o_seg = 7'b0001110;
      endcase
    end
  end

endmodule

module display7seg_mux #(
  parameter int N_DIGITS  = 4,
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_V  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  // Scan position
  logic [CW-1:0]              r_cnt;
  logic [IW-1:0]              r_idx;

  // Shadow (staged by load) and active (being displayed) buffers
  logic [N_DIGITS-1:0][3:0]   r_sh_val;
  logic [N_DIGITS-1:0]        r_sh_dp;
  logic                       r_sh_lz;
  logic                       r_pending;
  logic [N_DIGITS-1:0][3:0]   r_act_val;
  logic [N_DIGITS-1:0]        r_act_dp;
  logic                       r_act_lz;

  logic                       w_tick;
  logic                       w_frame;
  logic                       w_blank;
  logic [N_DIGITS-1:0][3:0]   w_val;
  logic [N_DIGITS-1:0]        w_allz;
  logic [N_DIGITS-1:0]        w_supp;
  logic [N_DIGITS-1:0][6:0]   w_dseg;
  logic [N_DIGITS-1:0]        w_an;

  assign w_val   = value;
  assign w_tick  = (r_cnt == CNT_LAST);
  assign w_frame = w_tick && (r_idx == IDX_LAST);
  assign w_blank = (r_cnt < BLANK_V);

  // w_allz[i]: active digits N_DIGITS-1 down to i are all zero
  always_comb begin
    w_allz = '0;
    w_allz[N_DIGITS-1] = (r_act_val[N_DIGITS-1] == 4'd0);
    for (int i = N_DIGITS - 2; i >= 0; i--)
      w_allz[i] = w_allz[i+1] && (r_act_val[i] == 4'd0);
  end

  // One decoder per digit; digit 0 is never blanked so a zero value still shows "0"
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_d0
      assign w_supp[g] = 1'b0;
    end else begin : g_dn
      assign w_supp[g] = r_act_lz && w_allz[g];
    end
    display7seg_digit u_dig (
      .i_hex  (r_act_val[g]),
      .i_supp (w_supp[g]),
      .o_seg  (w_dseg[g])
    );
  end

  // One-hot-low anode select for the current slot
  always_comb begin
    w_an = '1;
    w_an[r_idx] = 1'b0;
  end

  // Prescaler, digit index and shadow/active buffering
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_sh_lz   <= 1'b0;
      r_pending <= 1'b0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_act_lz  <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_sh_val <= w_val;
        r_sh_dp  <= dp;
        r_sh_lz  <= lz_en;
      end
      if (w_frame) begin
        // A load landing on the boundary bypasses the shadow so it shows at once
        if (load) begin
          r_act_val <= w_val;
          r_act_dp  <= dp;
          r_act_lz  <= lz_en;
        end else if (r_pending) begin
          r_act_val <= r_sh_val;
          r_act_dp  <= r_sh_dp;
          r_act_lz  <= r_sh_lz;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Registered display outputs, one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      seg        <= 7'b1111111;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame;
      if (w_blank) begin
        an   <= '1;
        seg  <= 7'b1111111;
        dp_n <= 1'b1;
      end else begin
        an   <= w_an;
        seg  <= w_dseg[r_idx];
        dp_n <= ~r_act_dp[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_display7seg_mux.sv
// Bench for display7seg_mux (4 digits, prescale 4, 1 blank cycle).
// Vectors carry the expected per-digit segments; a frame-level model picks
// which vector is on screen and queues the expected output for every cycle.
module tb_display7seg_mux;

  localparam int ND = 4;
  localparam int PS = 4;
  localparam int BC = 1;
  localparam logic [6:0] Z  = 7'b1000000;
  localparam logic [6:0] BL = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, lz_en, load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  display7seg_mux #(.N_DIGITS(ND), .PRESCALE(PS), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .lz_en(lz_en),
    .load(load), .seg(seg), .dp_n(dp_n), .an(an), .frame_done(frame_done)
  );

  typedef struct {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] eseg;
    logic [3:0]      edpn;
  } vec_t;

  typedef logic [12:0] exp_t;

  vec_t       vecs[23];
  logic [6:0] hexseg[16];
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cur = 0;

  int              m_cnt, m_idx;
  logic            m_pend;
  logic [3:0][6:0] m_aseg, m_sseg;
  logic [3:0]      m_adpn, m_sdpn;

  function automatic vec_t mk(logic [15:0] v, logic [3:0] d, logic l,
                              logic [3:0][6:0] s, logic [3:0] n);
    vec_t r;
    r.val = v; r.dp = d; r.lz = l; r.eseg = s; r.edpn = n;
    return r;
  endfunction

  // Push the expectation for this cycle's inputs, clock, then pop and compare
  task automatic cyc(input string nm);
    exp_t e, g;
    logic bnd;
    if (reset) begin
      e = {4'hF, BL, 1'b1, 1'b0};
      m_cnt = 0; m_idx = 0; m_pend = 1'b0;
      m_aseg = {Z, Z, Z, Z}; m_adpn = 4'hF;
      m_sseg = {Z, Z, Z, Z}; m_sdpn = 4'hF;
    end else begin
      bnd = (m_cnt == PS - 1) && (m_idx == ND - 1);
      if (m_cnt < BC) e[12:1] = {4'hF, BL, 1'b1};
      else e[12:1] = {~(4'b0001 << m_idx), m_aseg[m_idx], m_adpn[m_idx]};
      e[0] = bnd;
      if (bnd) begin
        if (load) begin
          m_aseg = vecs[cur].eseg; m_adpn = vecs[cur].edpn;
        end else if (m_pend) begin
          m_aseg = m_sseg; m_adpn = m_sdpn;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_sseg = vecs[cur].eseg; m_sdpn = vecs[cur].edpn; m_pend = 1'b1;
      end
      if (m_cnt == PS - 1) begin
        m_cnt = 0; m_idx = (m_idx + 1) % ND;
      end else begin
        m_cnt++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = {an, seg, dp_n, frame_done};
    e = sb.pop_front();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s @%0t: got an=%b seg=%b dp_n=%b fd=%b, expected an=%b seg=%b dp_n=%b fd=%b",
               nm, $time, g[12:9], g[8:2], g[1], g[0], e[12:9], e[8:2], e[1], e[0]);
    end
  endtask

  task automatic run(input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(nm);
  endtask

  // One-cycle load strobe; inputs are scrambled afterwards so only the strobe captures
  task automatic do_load(input int v, input string nm);
    value = vecs[v].val; dp = vecs[v].dp; lz_en = vecs[v].lz; load = 1'b1; cur = v;
    cyc(nm);
    load = 1'b0; value = 16'($urandom); dp = 4'($urandom); lz_en = 1'($urandom);
  endtask

  // Bounded advance until the model sits on the given slot position
  task automatic seek(input int cnt, input int idx, input string nm);
    int n;
    n = 0;
    while (!(m_cnt == cnt && m_idx == idx) && n < 20) begin
      cyc(nm);
      n++;
    end
    checks++;
    if (!(m_cnt == cnt && m_idx == idx)) begin
      errors++;
      $display("FAIL %s: slot position not reached, got cnt=%0d idx=%0d, expected cnt=%0d idx=%0d",
               nm, m_cnt, m_idx, cnt, idx);
    end
  endtask

  initial begin
    hexseg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    vecs[0] = mk(16'h1234, 4'b0000, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111);
    vecs[1] = mk(16'h00A0, 4'b0000, 1'b1, {BL, BL, 7'b0001000, Z}, 4'b1111);
    vecs[2] = mk(16'h00A0, 4'b0000, 1'b0, {Z, Z, 7'b0001000, Z}, 4'b1111);
    vecs[3] = mk(16'hAAAA, 4'b0000, 1'b0, {4{7'b0001000}}, 4'b1111);
    vecs[4] = mk(16'hF00D, 4'b0101, 1'b0, {7'b0001110, Z, Z, 7'b0100001}, 4'b1010);
    vecs[5] = mk(16'h0000, 4'b1000, 1'b1, {BL, BL, BL, Z}, 4'b0111);
    vecs[6] = mk(16'h0B00, 4'b0000, 1'b1, {BL, 7'b0000011, Z, Z}, 4'b1111);
    for (int h = 0; h < 16; h++)
      vecs[7+h] = mk({12'h000, 4'(h)}, 4'b0001, 1'b0, {Z, Z, Z, hexseg[h]}, 4'b1110);

    // Reset, with a load strobe during reset that must be ignored
    reset = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0; lz_en = 1'b0;
    cyc("reset");
    value = 16'h1234; load = 1'b1; cur = 0;
    cyc("reset_load");
    load = 1'b0;
    cyc("reset");
    reset = 1'b0;
    run(20, "idle_zero");

    // Table vectors, each loaded at a different offset into the frame
    for (int v = 0; v < 7; v++) begin
      run(v + 3, "pre");
      do_load(v, "vec_load");
      run(34, "vec_show");
    end

    // Second load while one is pending overwrites the shadow
    seek(0, 1, "seek_ovr");
    do_load(0, "ovr_a");
    run(2, "ovr_gap");
    do_load(3, "ovr_b");
    run(34, "ovr_show");

    // Load on the exact frame-boundary cycle shows in the very next frame
    seek(PS - 1, ND - 1, "seek_bnd");
    do_load(4, "bnd_load");
    run(20, "bnd_show");

    // Reset in slot 2 with a load pending: pending is discarded, display zeros
    seek(1, 0, "seek_rst");
    do_load(1, "rst_load");
    seek(1, 2, "seek_rst2");
    reset = 1'b1;
    cyc("rst_mid");
    reset = 1'b0;
    run(40, "after_rst");

    // Sweep every hex code on digit 0 with its decimal point lit
    for (int h = 0; h < 16; h++) begin
      do_load(7 + h, "hex_load");
      run(32, "hex_show");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
